// File: rtl/iic_codec_init_seq.sv
// Codec init sequencer: walks a register table through the IIC bus master one
// transaction per entry, retrying NACKed or timed-out entries and reporting status.
module iic_codec_init_seq #(
    parameter int N_ENTRIES = 32,
    parameter int RETRIES   = 3,
    parameter int TIMEOUT   = 4096,
    parameter int GAP       = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic [7:0]  tbl_addr_o,
    input  logic [23:0] tbl_data_i,
    output logic [7:0]  drv_DA_o,
    output logic [7:0]  drv_RA_o,
    output logic [7:0]  drv_data_o,
    output logic        drv_vld_o,
    input  logic        drv_rdy_i,
    input  logic [31:0] drv_ack_i,
    input  logic [31:0] drv_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  err_idx_o,
    output logic [31:0] err_ack_o,
    output logic [31:0] rdata_o,
    output logic [7:0]  entry_cnt_o
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [7:0]    LAST_IDX  = 8'(N_ENTRIES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
    localparam logic [2:0]    RETRY_MAX = 3'(RETRIES);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT_BUSY,
        S_WAIT_DONE, S_CHECK, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    start_hist_q, start_hist_d;
    logic [7:0]    idx_q, idx_d;
    logic [2:0]    retry_q, retry_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_flag_q, tmo_flag_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          issue_cnt_q, issue_cnt_d;
    logic [7:0]    tbl_addr_q, tbl_addr_d;
    logic [7:0]    da_q, da_d, ra_q, ra_d, data_q, data_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [7:0]    err_idx_q, err_idx_d;
    logic [31:0]   err_ack_q, err_ack_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [7:0]    entry_cnt_q, entry_cnt_d;

    logic          start_edge;
    logic [31:0]   ack_sampled;

    assign start_edge  = start_hist_q[0] & ~start_hist_q[1];
    // A timed-out attempt reports an all-ones ACK, so pass reduces to ack==0.
    assign ack_sampled = tmo_flag_q ? '1 : drv_ack_i;

    always_comb begin
        state_d      = state_q;
        start_hist_d = {start_hist_q[0], start_i};
        idx_d        = idx_q;
        retry_d      = retry_q;
        tmo_cnt_d    = tmo_cnt_q;
        tmo_flag_d   = tmo_flag_q;
        gap_cnt_d    = gap_cnt_q;
        issue_cnt_d  = issue_cnt_q;
        tbl_addr_d   = tbl_addr_q;
        da_d         = da_q;
        ra_d         = ra_q;
        data_d       = data_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        err_idx_d    = err_idx_q;
        err_ack_d    = err_ack_q;
        rdata_d      = rdata_q;
        entry_cnt_d  = entry_cnt_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_edge) begin
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    err_idx_d   = '0;
                    err_ack_d   = '0;
                    entry_cnt_d = '0;
                    idx_d       = '0;
                    retry_d     = '0;
                    busy_d      = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                tbl_addr_d = idx_q;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                {da_d, ra_d, data_d} = tbl_data_i;
                if (drv_rdy_i) begin
                    tmo_cnt_d   = '0;
                    tmo_flag_d  = 1'b0;
                    issue_cnt_d = 1'b0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE: begin
                if (tmo_cnt_q == TMO_LAST) begin
                    tmo_flag_d = 1'b1;
                    state_d    = S_CHECK;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (state_q == S_ISSUE) begin
                        issue_cnt_d = 1'b1;
                        if (issue_cnt_q) state_d = S_WAIT_BUSY;
                    end else if (state_q == S_WAIT_BUSY) begin
                        if (!drv_rdy_i) state_d = S_WAIT_DONE;
                    end else if (drv_rdy_i) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (ack_sampled == '0) begin
                    entry_cnt_d = entry_cnt_q + 1'b1;
                    retry_d     = '0;
                    if (da_q[0]) rdata_d = drv_rdata_i;
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end
                end else if (retry_q < RETRY_MAX) begin
                    retry_d   = retry_q + 1'b1;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else begin
                    err_idx_d = idx_q;
                    err_ack_d = ack_sampled;
                    err_d     = 1'b1;
                    done_d    = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = S_ERROR;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_FETCH;
                else gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            start_hist_q <= '0;
            idx_q        <= '0;
            retry_q      <= '0;
            tmo_cnt_q    <= '0;
            tmo_flag_q   <= 1'b0;
            gap_cnt_q    <= '0;
            issue_cnt_q  <= 1'b0;
            tbl_addr_q   <= '0;
            da_q         <= '0;
            ra_q         <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_idx_q    <= '0;
            err_ack_q    <= '0;
            rdata_q      <= '0;
            entry_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            start_hist_q <= start_hist_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tmo_flag_q   <= tmo_flag_d;
            gap_cnt_q    <= gap_cnt_d;
            issue_cnt_q  <= issue_cnt_d;
            tbl_addr_q   <= tbl_addr_d;
            da_q         <= da_d;
            ra_q         <= ra_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_idx_q    <= err_idx_d;
            err_ack_q    <= err_ack_d;
            rdata_q      <= rdata_d;
            entry_cnt_q  <= entry_cnt_d;
        end
    end

    assign tbl_addr_o  = tbl_addr_q;
    assign drv_DA_o    = da_q;
    assign drv_RA_o    = ra_q;
    assign drv_data_o  = data_q;
    assign drv_vld_o   = (state_q == S_ISSUE);
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_idx_o   = err_idx_q;
    assign err_ack_o   = err_ack_q;
    assign rdata_o     = rdata_q;
    assign entry_cnt_o = entry_cnt_q;
endmodule
